// File: rtl/ysyx_24090018_wbu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24090018_wbu
// Description : Writeback unit. Arbitrates ALU/LSU results onto the register
//               file write port and tracks pending destinations for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24090018_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    output logic                  hazard,
    input  logic                  alu_valid,
    input  logic                  alu_wen,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [63:0]           retire_cnt,
    output logic                  wb_err
);

    localparam int c_IDX_W = $clog2(REG_NUM);

    logic [REG_NUM-1:0]    r_pending;
    logic [REG_NUM-1:0]    w_pending_nxt;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic [63:0]           r_retire_cnt;
    logic                  r_wb_err;

    logic [c_IDX_W-1:0]    w_rs1_idx;
    logic [c_IDX_W-1:0]    w_rs2_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [c_IDX_W-1:0]    w_fire_idx;
    logic [c_IDX_W-1:0]    w_clr_idx;
    logic                  w_hazard;
    logic                  w_issue_acc;
    logic                  w_lsu_fire;
    logic                  w_alu_fire;
    logic                  w_fire;
    logic                  w_fire_wen;
    logic [ADDR_WIDTH-1:0] w_fire_rd;
    logic [DATA_WIDTH-1:0] w_fire_data;
    logic                  w_fire_nz;
    logic                  w_err_evt;
    logic                  w_unused;

    // Only the low address bits select a scoreboard entry (RV32E).
    assign w_rs1_idx  = issue_rs1[c_IDX_W-1:0];
    assign w_rs2_idx  = issue_rs2[c_IDX_W-1:0];
    assign w_rd_idx   = issue_rd[c_IDX_W-1:0];
    assign w_clr_idx  = r_rf_waddr[c_IDX_W-1:0];
    assign w_unused   = &{1'b0, issue_rs1[ADDR_WIDTH-1:c_IDX_W], issue_rs2[ADDR_WIDTH-1:c_IDX_W]};

    assign w_hazard    = issue_valid & (r_pending[w_rs1_idx] | r_pending[w_rs2_idx]
                                        | (issue_wen & r_pending[w_rd_idx]));
    assign w_issue_acc = issue_valid & ~w_hazard;

    // LSU has fixed priority; ALU is back-pressured whenever LSU presents.
    assign lsu_ready   = 1'b1;
    assign alu_ready   = ~lsu_valid;
    assign w_lsu_fire  = lsu_valid;
    assign w_alu_fire  = alu_valid & ~lsu_valid;
    assign w_fire      = w_lsu_fire | w_alu_fire;
    assign w_fire_wen  = w_lsu_fire ? lsu_wen  : alu_wen;
    assign w_fire_rd   = w_lsu_fire ? lsu_rd   : alu_rd;
    assign w_fire_data = w_lsu_fire ? lsu_data : alu_data;
    assign w_fire_idx  = w_fire_rd[c_IDX_W-1:0];
    assign w_fire_nz   = (w_fire_rd != '0);
    assign w_err_evt   = w_fire & w_fire_wen & w_fire_nz & ~r_pending[w_fire_idx];

    // Clear applied before set so a same-edge set of the same bit wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_rf_wen) begin
            w_pending_nxt[w_clr_idx] = 1'b0;
        end
        if (w_issue_acc && issue_wen && (issue_rd != '0)) begin
            w_pending_nxt[w_rd_idx] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_rf_wen     <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_retire_cnt <= '0;
            r_wb_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_fire) begin
                r_rf_wen     <= w_fire_wen & w_fire_nz;
                r_rf_waddr   <= w_fire_rd;
                r_rf_wdata   <= w_fire_data;
                r_retire_cnt <= r_retire_cnt + 64'd1;
            end else begin
                r_rf_wen     <= 1'b0;
            end
            if (w_err_evt) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign hazard     = w_hazard;
    assign rf_wen     = r_rf_wen;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign retire_cnt = r_retire_cnt;
    assign wb_err     = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090018_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24090018_wbu
// Description : Directed plus randomized bench for the writeback unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090018_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        hazard;
    logic        alu_valid, alu_wen, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_wen, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] retire_cnt;
    logic        wb_err;

    always #5 clk = ~clk;

    ysyx_24090018_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_NUM(16)) u_dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_wen(alu_wen), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_wen(lsu_wen), .lsu_rd(lsu_rd),
        .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_cnt(retire_cnt), .wb_err(wb_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural view of the writeback unit.
    bit              pend [16];
    bit              m_wen;
    bit [4:0]        m_waddr;
    bit [31:0]       m_wdata;
    longint unsigned m_cnt;
    bit              m_err;
    bit              alu_fired, lsu_fired, iss_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_err = 0;
        alu_fired = 0; lsu_fired = 0; iss_acc = 0;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_wen = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_wen = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic check_regs();
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("wb_err", wb_err, m_err);
    endtask

    // One clock cycle: check combinational outputs, predict, clock, check registers.
    task automatic step();
        bit        exp_haz, fire, fwen;
        bit [4:0]  frd;
        bit [31:0] fdat;
        bit        npend [16];
        #1;
        exp_haz = issue_valid && (pend[issue_rs1[3:0]] || pend[issue_rs2[3:0]]
                                  || (issue_wen && pend[issue_rd[3:0]]));
        chk("hazard", hazard, exp_haz);
        chk("alu_ready", alu_ready, !lsu_valid);
        chk("lsu_ready", lsu_ready, 1);
        lsu_fired = lsu_valid;
        alu_fired = alu_valid && !lsu_valid;
        fire = lsu_fired || alu_fired;
        fwen = lsu_fired ? lsu_wen  : alu_wen;
        frd  = lsu_fired ? lsu_rd   : alu_rd;
        fdat = lsu_fired ? lsu_data : alu_data;
        iss_acc = issue_valid && !exp_haz;
        npend = pend;
        if (m_wen) npend[m_waddr[3:0]] = 0;
        if (iss_acc && issue_wen && issue_rd != 0) npend[issue_rd[3:0]] = 1;
        if (fire && fwen && frd != 0 && !pend[frd[3:0]]) m_err = 1;
        @(posedge clk);
        #1;
        pend = npend;
        if (fire) begin
            m_wen = fwen && (frd != 0);
            m_waddr = frd;
            m_wdata = fdat;
            m_cnt++;
        end else begin
            m_wen = 0;
        end
        check_regs();
    endtask

    function automatic int pick_pending(input int excl);
        int cand [$];
        for (int i = 1; i < 16; i++)
            if (pend[i] && i != excl && !(m_wen && m_waddr == 5'(i))) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    initial begin
        int r;
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("rst_hazard", hazard, 0);
        rst = 0;

        // RAW on x5 resolved by an ALU writeback
        issue_valid = 1; issue_wen = 1; issue_rd = 5;
        step();
        issue_wen = 0; issue_rd = 0; issue_rs1 = 5;
        #1 chk("raw_hazard", hazard, 1);
        step();
        alu_valid = 1; alu_wen = 1; alu_rd = 5; alu_data = 32'h12345678;
        step();
        chk("raw_rf_wen", rf_wen, 1);
        chk("raw_waddr", rf_waddr, 5);
        chk("raw_wdata", rf_wdata, 32'h12345678);
        alu_valid = 0;
        #1 chk("raw_hazard_n1", hazard, 1);
        step();
        #1 chk("raw_release", hazard, 0);
        step();

        // Simultaneous ALU/LSU: LSU first, ALU next cycle
        issue_valid = 1; issue_wen = 1; issue_rs1 = 0; issue_rd = 3;
        step();
        issue_rd = 4;
        step();
        issue_valid = 0; issue_wen = 0; issue_rd = 0;
        alu_valid = 1; alu_wen = 1; alu_rd = 3; alu_data = 32'hAAAA0003;
        lsu_valid = 1; lsu_wen = 1; lsu_rd = 4; lsu_data = 32'h55550004;
        #1 chk("arb_alu_ready", alu_ready, 0);
        step();
        chk("arb_first", rf_waddr, 4);
        chk("arb_first_data", rf_wdata, 32'h55550004);
        lsu_valid = 0;
        step();
        chk("arb_second", rf_waddr, 3);
        chk("arb_cnt", retire_cnt, 64'd3);
        alu_valid = 0;

        // rd=0 result and issue
        alu_valid = 1; alu_wen = 1; alu_rd = 0; alu_data = 32'hDEADBEEF;
        step();
        chk("x0_rf_wen", rf_wen, 0);
        chk("x0_cnt", retire_cnt, 64'd4);
        chk("x0_err", wb_err, 0);
        alu_valid = 0;
        issue_valid = 1; issue_wen = 1; issue_rd = 0;
        #1 chk("x0_issue_haz", hazard, 0);
        step();
        issue_rs1 = 0; issue_wen = 0;
        #1 chk("x0_no_pend", hazard, 0);
        step();

        // WAW on x9
        issue_wen = 1; issue_rd = 9;
        step();
        #1 chk("waw_stall", hazard, 1);
        step();
        alu_valid = 1; alu_wen = 1; alu_rd = 9; alu_data = 32'h00000909;
        step();
        alu_valid = 0;
        step();
        #1 chk("waw_release", hazard, 0);
        step();
        issue_wen = 0; issue_rd = 0; issue_rs1 = 9;
        #1 chk("waw_reset_pend", hazard, 1);
        step();
        issue_valid = 0; issue_rs1 = 0;

        // Spurious writeback raises sticky error
        alu_valid = 1; alu_wen = 1; alu_rd = 7; alu_data = 32'h7;
        step();
        chk("err_set", wb_err, 1);
        alu_valid = 0;
        repeat (2) step();
        chk("err_sticky", wb_err, 1);

        // Asynchronous reset with x2 pending and a write in flight
        issue_valid = 1; issue_wen = 1; issue_rd = 2;
        step();
        issue_rd = 6;
        step();
        issue_valid = 0; issue_wen = 0; issue_rd = 0;
        alu_valid = 1; alu_wen = 1; alu_rd = 6; alu_data = 32'h66;
        step();
        alu_valid = 0;
        chk("pre_rst_wen", rf_wen, 1);
        issue_valid = 1; issue_rs1 = 2;
        #1 chk("pre_rst_haz", hazard, 1);
        rst = 1;
        #1;
        model_reset();
        check_regs();
        chk("rst_haz_drop", hazard, 0);
        #1 rst = 0;
        step();
        issue_valid = 0; issue_rs1 = 0;

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!(issue_valid && !iss_acc)) begin
                issue_valid = ($urandom_range(0, 1) == 1);
                issue_wen   = ($urandom_range(0, 3) != 0);
                issue_rd    = 5'($urandom_range(0, 15));
                issue_rs1   = 5'($urandom_range(0, 15));
                issue_rs2   = 5'($urandom_range(0, 15));
            end
            if (!(alu_valid && !alu_fired)) begin
                r = pick_pending(-1);
                alu_valid = (r >= 0) && ($urandom_range(0, 1) == 1);
                alu_wen   = ($urandom_range(0, 7) != 0);
                alu_rd    = (r >= 0) ? 5'(r) : 5'd0;
                alu_data  = $urandom;
            end
            r = pick_pending(alu_valid ? int'(alu_rd) : -1);
            lsu_valid = (r >= 0) && ($urandom_range(0, 2) == 0);
            lsu_wen   = ($urandom_range(0, 7) != 0);
            lsu_rd    = (r >= 0) ? 5'(r) : 5'd0;
            lsu_data  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
